// File: rtl/efuse_pkg.sv
// Shared types and default timing constants for the eFuse clock monitor.
// Periods are counted in int_clock cycles.
package efuse_pkg;

    localparam int DEF_MIN_PERIOD = 18;
    localparam int DEF_MAX_PERIOD = 22;
    localparam int DEF_TIMEOUT    = 64;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int CNT_W          = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_CHECK,
        ST_LOCKED,
        ST_FAULT
    } mon_state_t;

    typedef struct packed {
        logic             clk_ok;
        logic             clk_lost;
        logic             freq_err;
        logic             meas_valid;
        logic [CNT_W-1:0] period;
    } mon_out_t;

    function automatic logic in_window(input logic [CNT_W-1:0] p, input int lo, input int hi);
        return (int'(p) >= lo) && (int'(p) <= hi);
    endfunction

endpackage

// File: rtl/efuse_sync_edge.sv
// Two-flop synchronizer for the asynchronous clk_in plus a history flop;
// rise is high for one int_clock cycle per synchronized rising edge.
module efuse_sync_edge (
    input  logic int_clock,
    input  logic rst,
    input  logic d_async,
    output logic rise
);

    // sync_q[0] = sync1, sync_q[1] = sync2, sync_q[2] = sync3 (history)
    logic [2:0] sync_q;

    always_ff @(posedge int_clock or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], d_async};
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/efuse_clk_monitor.sv
// Measures the clk_in period against int_clock, locks after a run of in-range
// periods and raises sticky faults for a lost or off-frequency clock.
module efuse_clk_monitor
    import efuse_pkg::*;
#(
    parameter int MIN_PERIOD = DEF_MIN_PERIOD,
    parameter int MAX_PERIOD = DEF_MAX_PERIOD,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic             int_clock,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             enable,
    input  logic             clear_err,
    output logic             clk_ok,
    output logic             clk_lost,
    output logic             freq_err,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period
);

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam int               GOOD_W = $clog2(LOCK_COUNT + 1);

    mon_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    mon_out_t          out_q, out_d;
    logic              rise;
    logic              in_range;
    logic              timeout;

    efuse_sync_edge u_sync (
        .int_clock (int_clock),
        .rst       (rst),
        .d_async   (clk_in),
        .rise      (rise)
    );

    assign in_range = in_window(cnt_q, MIN_PERIOD, MAX_PERIOD);
    // A rise in the saturated cycle takes priority over the timeout.
    assign timeout  = (cnt_q == TO_VAL) && !rise;

    always_ff @(posedge int_clock or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            good_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        good_d            = good_q;
        out_d             = out_q;
        out_d.meas_valid  = 1'b0;

        if (rise)                 cnt_d = CNT_W'(1);
        else if (cnt_q != TO_VAL) cnt_d = cnt_q + CNT_W'(1);
        else                      cnt_d = cnt_q;

        // The first rise after ACQUIRE only opens the window; later ones measure.
        if (rise && (state_q == ST_CHECK || state_q == ST_LOCKED || state_q == ST_FAULT)) begin
            out_d.period     = cnt_q;
            out_d.meas_valid = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                good_d = '0;
                if (enable) state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (rise) begin
                    state_d = ST_CHECK;
                    good_d  = '0;
                end else if (timeout) begin
                    state_d        = ST_FAULT;
                    out_d.clk_lost = 1'b1;
                    out_d.clk_ok   = 1'b0;
                end
            end
            ST_CHECK: begin
                if (rise) begin
                    if (in_range) begin
                        good_d = good_q + GOOD_W'(1);
                        if (int'(good_q) + 1 >= LOCK_COUNT) begin
                            state_d      = ST_LOCKED;
                            out_d.clk_ok = 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    state_d        = ST_FAULT;
                    out_d.clk_lost = 1'b1;
                    out_d.clk_ok   = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (rise) begin
                    if (!in_range) begin
                        state_d        = ST_FAULT;
                        out_d.freq_err = 1'b1;
                        out_d.clk_ok   = 1'b0;
                    end
                end else if (timeout) begin
                    state_d        = ST_FAULT;
                    out_d.clk_lost = 1'b1;
                    out_d.clk_ok   = 1'b0;
                end
            end
            ST_FAULT: begin
                out_d.clk_ok = 1'b0;
                if (clear_err) begin
                    state_d        = ST_ACQUIRE;
                    out_d.clk_lost = 1'b0;
                    out_d.freq_err = 1'b0;
                    cnt_d          = '0;
                    good_d         = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disable overrides everything except the held period value.
        if (!enable) begin
            state_d          = ST_IDLE;
            cnt_d            = '0;
            good_d           = '0;
            out_d.clk_ok     = 1'b0;
            out_d.clk_lost   = 1'b0;
            out_d.freq_err   = 1'b0;
            out_d.meas_valid = 1'b0;
        end
    end

    assign clk_ok     = out_q.clk_ok;
    assign clk_lost   = out_q.clk_lost;
    assign freq_err   = out_q.freq_err;
    assign meas_valid = out_q.meas_valid;
    assign period     = out_q.period;

endmodule
